// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
//
// Owns the program counter and drives the instruction-memory address. The
// memory read is combinational, so the instruction for the current pc arrives
// in the same cycle and is captured into IF/ID on the next rising edge.
//
// Ports:
//   clk            core clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset, overrides everything else
//   stall          load-use stall, holds pc and IF/ID
//   branch_taken   taken branch/jump from EX, redirects pc and flushes IF/ID
//   branch_target  redirect address (low two bits ignored)
//   imem_rdata     instruction read at imem_addr
//   imem_addr      current pc (the pc register itself)
//   if_id_pc       pc of the instruction held in IF/ID
//   if_id_instr    instruction held in IF/ID
//   if_id_valid    IF/ID holds a real instruction (0 = bubble)
//   stall_count    honoured stall cycles, saturating
//   flush_count    redirects taken, saturating
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  pc_q,        pc_d;
  logic [XLEN-1:0]  if_pc_q,     if_pc_d;
  logic [XLEN-1:0]  if_instr_q,  if_instr_d;
  logic             if_valid_q,  if_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Priority: redirect beats stall beats advance. A stall coinciding with a
  // redirect is not counted, since its consumer is squashed anyway.
  always_comb begin
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (branch_taken) begin
      pc_d       = {branch_target[XLEN-1:2], 2'b00};
      if_pc_d    = '0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
      if (flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end else if (stall) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      pc_d       = pc_q + PC_STEP;
      if_pc_d    = pc_q;
      if_instr_d = imem_rdata;
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_pc_q     <= '0;
      if_instr_q  <= NOP_INSTR;
      if_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_instr = if_instr_q;
  assign if_id_valid = if_valid_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and drives the instruction-memory address.
- Consumes the load-use `stall` produced by the hazard-detection stage and the `branch_taken` redirect from EX.
- Presents {PC, instruction, valid} to the decode stage; keeps saturating stall/flush event counters for performance debug.

Parameters:
- XLEN, 32, PC and instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) injected on flush/reset
- CNT_W, 16, width of each event counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- stall  input  1  load-use stall from hazard-detection stage; hold PC and IF/ID
- branch_taken  input  1  EX resolved a taken branch/jump; redirect and flush
- branch_target  input  XLEN  redirect address, valid when branch_taken=1
- imem_rdata  input  XLEN  instruction at imem_addr, combinational read (same cycle)
- imem_addr  output  XLEN  current PC (equal to the pc register)
- if_id_pc  output  XLEN  PC of instruction held in IF/ID
- if_id_instr  output  XLEN  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- stall_count  output  CNT_W  cycles in which a stall was honoured, saturating
- flush_count  output  CNT_W  redirects taken, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) has highest priority and overrides stall and branch_taken. Reset values:
  - pc = RESET_PC
  - if_id_pc = 0
  - if_id_instr = NOP_INSTR
  - if_id_valid = 0
  - stall_count = 0
  - flush_count = 0
- Reset asserted mid-stall or mid-redirect discards all in-flight state.
- Per-edge priority with rst_n=1: branch_taken > stall > advance.
- Redirect (branch_taken=1, stall ignored):
  - pc <= {branch_target[XLEN-1:2], 2'b00}; bits [1:0] forced to zero.
  - IF/ID <= {pc: 0, instr: NOP_INSTR, valid: 0}.
  - flush_count increments.
  - stall_count is not incremented even if stall=1. The stalled consumer is being squashed anyway.
- Stall (stall=1, branch_taken=0):
  - pc holds.
  - if_id_pc, if_id_instr and if_id_valid hold their current values.
  - stall_count increments.
  - Consecutive stall cycles hold indefinitely; no timeout.
- Advance (both 0):
  - pc <= pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - IF/ID <= {pc, imem_rdata, 1}.
- imem_addr = pc at all times; zero-latency combinational read is assumed of the memory.
- Latency: an instruction fetched in cycle N is visible on if_id_* after edge N+1. Redirect target appears on imem_addr after 1 edge; its instruction reaches IF/ID after 2 edges. Net branch penalty: one bubble from this stage (the EX-side squash is outside this block).
- Counters saturate at 2^CNT_W-1 and never wrap; they are cleared only by reset.
- All outputs are registered except imem_addr, which is the pc register itself. No combinational path from any input to any output.
- First valid instruction after reset: the edge after rst_n deasserts loads IF/ID with {RESET_PC, mem[RESET_PC], 1}.

Test Plan:
- Reset then run: imem returns addr^32'hA5A5_0000, rst_n low 2 cycles then high -> imem_addr = 0,4,8,12 on successive cycles; if_id_valid 0 then 1; if_id_pc = 0,4,8 lagging imem_addr by one cycle; if_id_instr matches.
- Load-use stall: stall=1 for 2 cycles while pc=0x10 -> imem_addr stays 0x10; if_id_* frozen at {0x0C, instr, 1}; stall_count=2; advance resumes with pc=0x14.
- Redirect: branch_taken=1, branch_target=0x0000_0203 at pc=0x20 -> next imem_addr=0x200; IF/ID = {0, 0x13, 0}; flush_count=1; the edge after that gives if_id_pc=0x200, valid=1.
- Simultaneous stall+branch_taken: target 0x80 -> redirect wins; imem_addr=0x80; IF/ID bubble; flush_count +1; stall_count unchanged.
- Wrap and saturation: RESET_PC=32'hFFFF_FFF8, CNT_W=2 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Hold stall 5 cycles -> stall_count sticks at 3.
- Reset mid-stall: stall=1 at pc=0x40 with stall_count=3, rst_n=0 one cycle -> pc=RESET_PC, counters 0, if_id_valid=0 regardless of stall still being high.
